// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a one-cycle registered output stage and a
// single skid entry, so in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
   parameter int DATA_WIDTH    = 32,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instr,
   input  logic [2:0]               imm_src,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    imm_ext,
   output logic                     imm_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic [2:0] SRC_I     = 3'b000;
   localparam logic [2:0] SRC_S     = 3'b001;
   localparam logic [2:0] SRC_B     = 3'b010;
   localparam logic [2:0] SRC_U     = 3'b011;
   localparam logic [2:0] SRC_J     = 3'b100;
   localparam logic [2:0] SRC_SHAMT = 3'b101;

   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

   logic [DATA_WIDTH-1:0] dec_ext;
   logic                  dec_err;
   logic [5:0]            shamt;

   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_ext;
   logic                  skid_err;

   logic                  accept;
   logic                  out_free;

   // The opcode field never contributes to any immediate format.
   logic unused_opcode;
   assign unused_opcode = ^instr[6:0];

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      dec_ext = '0;
      dec_err = 1'b0;
      shamt   = instr[25:20];
      if (DATA_WIDTH != 64) shamt[5] = 1'b0;
      case (imm_src)
         SRC_I:     dec_ext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
         SRC_S:     dec_ext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
         SRC_B:     dec_ext = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
         SRC_U:     dec_ext = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
         SRC_J:     dec_ext = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
         SRC_SHAMT: dec_ext = {{(DATA_WIDTH-6){1'b0}}, shamt};
         default:   dec_err = 1'b1;
      endcase
   end

   // in_ready comes straight from the skid flag; rst only masks it while held.
   assign in_ready = !skid_valid && !rst;
   assign accept   = in_valid && in_ready;
   assign out_free = !out_valid || out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         imm_ext    <= '0;
         imm_err    <= 1'b0;
         skid_valid <= 1'b0;
         skid_ext   <= '0;
         skid_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         if (out_free) begin
            if (skid_valid) begin
               // Skid drains first; in_ready was low so nothing new arrives.
               out_valid  <= 1'b1;
               imm_ext    <= skid_ext;
               imm_err    <= skid_err;
               skid_valid <= 1'b0;
            end else if (accept) begin
               out_valid <= 1'b1;
               imm_ext   <= dec_ext;
               imm_err   <= dec_err;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ext   <= dec_ext;
            skid_err   <= dec_err;
         end

         if (accept && dec_err && (err_count != ERR_MAX))
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the sign-extended immediate output; legal values are 32 and 64.
REQ-002 Parameter ERR_CNT_WIDTH, default 8, width of the illegal-selector counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream presents instr/imm_src.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 instr  input  32  raw instruction word.
REQ-008 imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110/111 illegal.
REQ-009 out_valid  output  1  imm_ext/imm_err hold a valid result.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 imm_ext  output  DATA_WIDTH  decoded immediate.
REQ-012 imm_err  output  1  result came from an illegal imm_src.
REQ-013 err_count  output  ERR_CNT_WIDTH  saturating count of accepted illegal selectors.

Function
REQ-014 Decode rules, all sign-extended from instr[31] to DATA_WIDTH:
- I = instr[31:20].
- S = {instr[31:25], instr[11:7]}.
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U = {instr[31:12], 12'b0}.
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-015 SHAMT SHALL zero-extend instr[25:20] when DATA_WIDTH=64 and instr[24:20] when DATA_WIDTH=32.
REQ-016 For an illegal imm_src, imm_ext SHALL be 0 and imm_err SHALL be 1; otherwise imm_err SHALL be 0.
REQ-017 A transfer is accepted when in_valid && in_ready; it is delivered when out_valid && out_ready.
REQ-018 Latency SHALL be exactly 1 cycle: a result accepted at edge N is visible on the outputs after edge N when the output stage is empty or draining.
REQ-019 Storage SHALL be one output register plus one skid entry; in_ready SHALL equal !skid_valid and be driven from a register, with no combinational path from out_ready.
REQ-020 Output full, out_ready=0, accept: the new result SHALL go to the skid entry and in_ready SHALL be 0 from the next cycle.
REQ-021 Output full, out_ready=1, skid empty, accept: the output register SHALL load the new result in the same edge, with no bubble.
REQ-022 Skid full, out_ready=1: the output SHALL load the skid entry, and in_ready SHALL return to 1 the next cycle.
REQ-023 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 With out_ready held at 1, sustained throughput SHALL be 1 result per cycle.
REQ-025 imm_ext and imm_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 err_count SHALL increment on each accepted illegal selector and SHALL saturate at 2^ERR_CNT_WIDTH-1 without wrapping.
REQ-027 imm_src and instr SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst=1, in_ready SHALL be 0 and no transfer SHALL be accepted or delivered.
REQ-029 After any edge with rst=1, the outputs SHALL be: out_valid=0, skid empty, imm_ext=0, imm_err=0, err_count=0.
REQ-030 in_ready SHALL be 1 in the first cycle with rst=0.
REQ-031 Reset asserted mid-stream SHALL discard buffered results, including any held in the skid entry.

Verification
REQ-032 Each format test drives out_ready=1 and checks the output one cycle after acceptance:
- I, instr 0xFFF00093, src 000 -> imm_ext 0xFFFFFFFF.
- S, instr 0xFE20AE23, src 001 -> 0xFFFFFFFC.
- B, instr 0x00000463, src 010 -> 0x00000008.
- U, instr 0x123450B7, src 011 -> 0x12345000.
- J, instr 0x001000EF, src 100 -> 0x00000800.
REQ-033 DATA_WIDTH=64 sign extension: instr 0xFFF00093, src 000 -> imm_ext 0xFFFFFFFFFFFFFFFF. SHAMT: instr 0x03F0D093, src 101 -> 0x000000000000003F.
REQ-034 Backpressure: out_ready=0 while three results A, B, C are offered on consecutive cycles.
- A and B SHALL be accepted; in_ready SHALL fall after B and C SHALL be held.
- Raising out_ready SHALL deliver A, B, C in order, one per cycle.
REQ-035 Illegal selector: src 110 with instr 0xFFFFFFFF -> imm_ext 0, imm_err 1, err_count 1.
- With ERR_CNT_WIDTH=2, five illegal transfers SHALL leave err_count at 3.
REQ-036 Reset mid-operation: skid full and out_ready=0, then rst pulsed for 1 cycle.
- The next cycle SHALL show out_valid=0, in_ready=1 and err_count=0.
- No stale result SHALL appear afterwards.
REQ-037 Simultaneous accept and deliver: continuous streaming of 8 transfers with out_ready=1 SHALL produce 8 consecutive out_valid cycles with in_ready held at 1.
